// File: rtl/rca_multiword_seq_pkg.sv
// rca_multiword_seq_pkg: shared state encoding, default sizes and index-width helper
`default_nettype none

package rca_multiword_seq_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_SLICE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slice index counter width; a single-slice configuration still needs one bit.
  function automatic int unsigned idx_width(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rca_multiword_seq_if.sv
// rca_multiword_seq_if: start/busy/done request bus between requester and the sequencer
`default_nettype none

interface rca_multiword_seq_if
  import rca_multiword_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  ready, busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output ready, busy, done, sum, cout, ovf
  );

endinterface

`default_nettype wire

// File: rtl/rca_multiword_seq_slice.sv
// rca_slice4: combinational SLICE-bit ripple chain of full adders
`default_nettype none

module rca_slice4 #(
  parameter int unsigned SLICE = 4
) (
  input  wire logic [SLICE-1:0] a_i,
  input  wire logic [SLICE-1:0] b_i,
  input  wire logic             cin_i,
  output logic      [SLICE-1:0] sum_o,
  output logic                  cout_o,
  output logic                  cmsb_o
);

  logic [SLICE:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[SLICE];
  // Carry into the top stage, used by the caller for signed overflow.
  assign cmsb_o = c[SLICE-1];

endmodule

`default_nettype wire

// File: rtl/rca_multiword_seq.sv
// rca_multiword_seq: WIDTH-bit add/subtract computed one SLICE-bit ripple slice per clock
`default_nettype none

module rca_multiword_seq
  import rca_multiword_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  wire logic          clk,
  input  wire logic          rst,
  rca_multiword_seq_if.slave bus_if
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = idx_width(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;

  assign slice_a = a_q[idx_q*SLICE +: SLICE];
  assign slice_b = b_q[idx_q*SLICE +: SLICE];

  rca_slice4 #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout),
    .cmsb_o (slice_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus_if.start) begin
          // Subtraction is a + ~b + 1, so cin is replaced by the forced 1.
          a_d     = bus_if.a;
          b_d     = bus_if.sub ? ~bus_if.b : bus_if.b;
          carry_d = bus_if.sub ? 1'b1 : bus_if.cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*SLICE +: SLICE] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus_if.ready = (state_q == ST_IDLE);
  assign bus_if.busy  = (state_q == ST_RUN);
  assign bus_if.done  = (state_q == ST_DONE);
  assign bus_if.sum   = sum_q;
  assign bus_if.cout  = cout_q;
  assign bus_if.ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rca_multiword_seq.sv
// tb_rca_multiword_seq: directed vectors with a result scoreboard checked on every done pulse
`default_nettype none

module tb_rca_multiword_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SLICE = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  logic clk;
  logic rst;

  rca_multiword_seq_if #(.WIDTH(WIDTH)) bus_if ();

  rca_multiword_seq #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  result_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_issued = 0;
  int n_done   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus_if.done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        chk("sum",  32'(bus_if.sum),  32'(e.sum));
        chk("cout", 32'(bus_if.cout), 32'(e.cout));
        chk("ovf",  32'(bus_if.ovf),  32'(e.ovf));
      end
    end
  end

  task automatic wait_ready();
    int cnt = 0;
    while (bus_if.ready !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (bus_if.ready !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one operation; interfere=1 pulses a second start on the 2nd RUN cycle.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub,
                       input logic [WIDTH-1:0] e_sum, input logic e_cout,
                       input logic e_ovf, input bit interfere);
    int cyc;
    bit seen;
    wait_ready();
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.cin   = cin;
    bus_if.sub   = sub;
    bus_if.start = 1'b1;
    exp_q.push_back('{sum: e_sum, cout: e_cout, ovf: e_ovf});
    n_issued++;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.a     = ~a;
    bus_if.b     = ~b;
    bus_if.cin   = ~cin;
    bus_if.sub   = ~sub;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_run", 32'(bus_if.busy), 32'd1);
      if (cyc == 2 && interfere) begin
        bus_if.a     = 16'hAAAA;
        bus_if.b     = 16'h5555;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
      end
      if (bus_if.done === 1'b1) seen = 1'b1;
    end
    chk("latency", 32'(cyc), 32'd5);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus_if.done), 32'd0);
    chk("ready_after", 32'(bus_if.ready), 32'd1);
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.sub   = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.cin   = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus_if.ready), 32'd1);
    chk("rst_busy",  32'(bus_if.busy),  32'd0);
    chk("rst_done",  32'(bus_if.done),  32'd0);
    chk("rst_sum",   32'(bus_if.sum),   32'd0);
    chk("rst_cout",  32'(bus_if.cout),  32'd0);
    chk("rst_ovf",   32'(bus_if.ovf),   32'd0);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    do_op(16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    do_op(16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    // Start during RUN must be ignored: same result, single done.
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("no_queued_op", 32'(bus_if.ready), 32'd1);

    // Reset on the 3rd RUN cycle discards the operation.
    wait_ready();
    bus_if.a     = 16'hFFFF;
    bus_if.b     = 16'hFFFF;
    bus_if.cin   = 1'b1;
    bus_if.sub   = 1'b0;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(bus_if.ready), 32'd1);
    chk("midrst_busy",  32'(bus_if.busy),  32'd0);
    chk("midrst_done",  32'(bus_if.done),  32'd0);
    chk("midrst_sum",   32'(bus_if.sum),   32'd0);
    repeat (6) @(negedge clk);
    do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("done_count", 32'(n_done), 32'(n_issued));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
